// File: rtl/sram_pkg.sv
// Shared SRAM constants, reader FSM state type and byte-select helper.
package sram_pkg;

  localparam int SRAM_ADDR_W = 20;
  localparam int SRAM_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DONE
  } rd_state_t;

  // Byte lane selection: 0 = low byte, 1 = high byte
  function automatic logic [7:0] selByte(input logic [SRAM_DATA_W-1:0] word, input logic hi);
    return hi ? word[15:8] : word[7:0];
  endfunction

endpackage

// File: rtl/sram_if.sv
// SRAM bus bundle: address, active-low strobes and read data.
interface sram_if;

  logic [sram_pkg::SRAM_ADDR_W-1:0] sram_addr;
  logic                             nCE;
  logic                             nOE;
  logic                             nWE;
  logic                             nLB;
  logic                             nUB;
  logic [sram_pkg::SRAM_DATA_W-1:0] sram_dq_in;

  modport master (
    output sram_addr, nCE, nOE, nWE, nLB, nUB,
    input  sram_dq_in
  );

  modport slave (
    input  sram_addr, nCE, nOE, nWE, nLB, nUB,
    output sram_dq_in
  );

endinterface

// File: rtl/sram_rd_fifo.sv
// Synchronous word FIFO with flush; head word is visible combinationally.
module sram_rd_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         pushData,
  input  logic                     pop,
  output logic [WIDTH-1:0]         headData,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr;
  logic [AW-1:0]    rdPtr;
  logic             doPush;
  logic             doPop;

  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(DEPTH));
  assign doPop    = pop && !empty;
  // A pop frees a slot in the same cycle, so a push is accepted even when full
  assign doPush   = push && (!full || doPop);
  assign headData = mem[rdPtr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + AW'(1);
      if (doPop)  rdPtr <= rdPtr + AW'(1);
      case ({doPush, doPop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (doPush && !rst && !flush) mem[wrPtr] <= pushData;
  end

endmodule

// File: rtl/sram_line_reader.sv
// Fetches one video line from async SRAM into a prefetch FIFO, emits bytes low-first.
// Optional SRAM_RD_UNDERFLOW_CNT_EN adds a saturating underflow_cnt output.
module sram_line_reader
  import sram_pkg::*;
#(
  parameter int LINE_WORDS = 400,
  parameter int FIFO_DEPTH = 8,
  parameter int READ_LAT   = 1
) (
  input  logic                   pixel_clk,
  input  logic                   R,
  input  logic                   bus_grant,
  input  logic                   line_start,
  input  logic [SRAM_ADDR_W-1:0] line_base,
  input  logic                   pix_rd,
  sram_if.master                 bus,
  output logic [7:0]             pix_data,
  output logic                   pix_valid,
  output logic                   underflow
`ifdef SRAM_RD_UNDERFLOW_CNT_EN
  ,
  output logic [15:0]            underflow_cnt
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int IW = $clog2(LINE_WORDS + 1);
  localparam logic [CW:0]   DEPTH_LIM = (CW+1)'(FIFO_DEPTH);
  localparam logic [IW-1:0] LAST_IDX  = IW'(LINE_WORDS - 1);

  rd_state_t              state;
  rd_state_t              stateNext;
  logic [SRAM_ADDR_W-1:0] curAddr;
  logic [SRAM_ADDR_W-1:0] addrReg;
  logic [IW-1:0]          issuedCnt;
  logic                   strobeLow;
  logic [READ_LAT-1:0]    rdPipe;
  logic [CW-1:0]          inflight;
  logic [CW-1:0]          fifoCount;
  logic [CW:0]            occupancy;
  logic                   issue;
  logic                   lastIssue;
  logic                   fifoPush;
  logic                   fifoPop;
  logic                   fifoEmpty;
  logic                   fifoFull;
  logic [SRAM_DATA_W-1:0] headWord;
  logic                   bytePtr;

  sram_rd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (SRAM_DATA_W)
  ) u_fifo (
    .clk      (pixel_clk),
    .rst      (R),
    .flush    (line_start),
    .push     (fifoPush),
    .pushData (bus.sram_dq_in),
    .pop      (fifoPop),
    .headData (headWord),
    .count    (fifoCount),
    .empty    (fifoEmpty),
    .full     (fifoFull)
  );

  // Reads still on the bus count against FIFO space so a stalled consumer never overflows it
  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i < READ_LAT; i++) inflight = inflight + CW'(rdPipe[i]);
    occupancy = {1'b0, fifoCount} + {1'b0, inflight};
  end

  always_comb begin
    stateNext = state;
    issue     = 1'b0;
    lastIssue = (issuedCnt == LAST_IDX);
    if (line_start) begin
      stateNext = FETCH;
    end else begin
      case (state)
        FETCH: begin
          issue = bus_grant && !fifoFull && (occupancy < DEPTH_LIM);
          if (issue && lastIssue) stateNext = DONE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge pixel_clk) begin
    if (R) state <= IDLE;
    else   state <= stateNext;
  end

  // rdPipe[k] marks a read issued k+1 edges ago; clearing it on line_start kills stale data
  always_ff @(posedge pixel_clk) begin
    if (R) begin
      curAddr   <= '0;
      addrReg   <= '0;
      issuedCnt <= '0;
      strobeLow <= 1'b0;
      rdPipe    <= '0;
      bytePtr   <= 1'b0;
      underflow <= 1'b0;
    end else begin
      strobeLow <= issue;
      underflow <= pix_rd && !pix_valid;
      if (issue) addrReg <= curAddr;
      if (line_start) begin
        curAddr   <= line_base;
        issuedCnt <= '0;
        rdPipe    <= '0;
        bytePtr   <= 1'b0;
      end else begin
        if (issue) begin
          curAddr   <= curAddr + SRAM_ADDR_W'(1);
          issuedCnt <= issuedCnt + IW'(1);
        end
        rdPipe[0] <= issue;
        for (int unsigned i = 1; i < READ_LAT; i++) rdPipe[i] <= rdPipe[i-1];
        if (pix_rd && pix_valid) bytePtr <= !bytePtr;
      end
    end
  end

  assign fifoPush = rdPipe[READ_LAT-1] && !line_start;
  assign fifoPop  = pix_rd && bytePtr;

  assign pix_valid = !fifoEmpty;
  assign pix_data  = fifoEmpty ? '0 : selByte(headWord, bytePtr);

  assign bus.sram_addr = addrReg;
  assign bus.nCE       = !strobeLow;
  assign bus.nOE       = !strobeLow;
  assign bus.nLB       = !strobeLow;
  assign bus.nUB       = !strobeLow;
  assign bus.nWE       = 1'b1;

`ifdef SRAM_RD_UNDERFLOW_CNT_EN
  always_ff @(posedge pixel_clk) begin
    if (R)                                     underflow_cnt <= '0;
    else if (underflow && underflow_cnt != '1) underflow_cnt <= underflow_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_sram_line_reader.sv
// Directed scoreboard bench: two readers (400 words / latency 1, 4 words / latency 2).
module tb_sram_line_reader;
  import sram_pkg::*;

  logic pixel_clk = 1'b0;
  always #5 pixel_clk = ~pixel_clk;

  logic        R;
  logic        grantA, lineStartA, pixRdA, pixValidA, underflowA;
  logic        grantB, lineStartB, pixRdB, pixValidB, underflowB;
  logic [19:0] baseA, baseB;
  logic [7:0]  pixDataA, pixDataB;
`ifdef SRAM_RD_UNDERFLOW_CNT_EN
  logic [15:0] ufRegA, ufRegB;
`endif

  sram_if busA();
  sram_if busB();

  sram_line_reader #(.LINE_WORDS(400), .FIFO_DEPTH(8), .READ_LAT(1)) u_dutA (
    .pixel_clk (pixel_clk), .R (R), .bus_grant (grantA), .line_start (lineStartA),
    .line_base (baseA), .pix_rd (pixRdA), .bus (busA), .pix_data (pixDataA),
    .pix_valid (pixValidA), .underflow (underflowA)
`ifdef SRAM_RD_UNDERFLOW_CNT_EN
    , .underflow_cnt (ufRegA)
`endif
  );

  sram_line_reader #(.LINE_WORDS(4), .FIFO_DEPTH(8), .READ_LAT(2)) u_dutB (
    .pixel_clk (pixel_clk), .R (R), .bus_grant (grantB), .line_start (lineStartB),
    .line_base (baseB), .pix_rd (pixRdB), .bus (busB), .pix_data (pixDataB),
    .pix_valid (pixValidB), .underflow (underflowB)
`ifdef SRAM_RD_UNDERFLOW_CNT_EN
    , .underflow_cnt (ufRegB)
`endif
  );

  function automatic logic [15:0] memWord(input logic [19:0] a);
    return a[15:0] ^ 16'hA5A5;
  endfunction

  // Latency-1 SRAM: data valid during the strobe cycle; 16'hDEAD when not enabled
  assign busA.sram_dq_in = busA.nOE ? 16'hDEAD : memWord(busA.sram_addr);

  // Latency-2 SRAM: data valid the cycle after the strobe cycle
  logic [19:0] addrDB;
  logic        oeDB;
  always @(posedge pixel_clk) begin
    addrDB <= busB.sram_addr;
    oeDB   <= busB.nOE;
  end
  assign busB.sram_dq_in = oeDB ? 16'hDEAD : memWord(addrDB);

  int compared   = 0;
  int mismatched = 0;

  logic [7:0]  sbA[$];
  logic [7:0]  sbB[$];
  logic [19:0] obsAddrB[$];

  logic        consumeA = 0, consumeB = 0, toggleA = 0, forceRdA = 0;
  logic        reqStartA = 0, reqStartB = 0, armKillB = 0, prevLowB = 0;
  logic        ufExpA = 0, ufExpB = 0;
  logic [19:0] startBaseA = '0, startBaseB = '0;
  int          issueCntA = 0, ufPulsesA = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic [31:0] exp;
    logic [19:0] a;
    @(negedge pixel_clk);
    // ---- reader A observation
    check("strobeA_grp", 32'({busA.nOE, busA.nLB, busA.nUB}), 32'({3{busA.nCE}}));
    if (!grantA) check("strobeA_nogrant", 32'(busA.nCE), 32'd1);
    if (!busA.nCE) issueCntA++;
    if (underflowA) ufPulsesA++;
    check("ufA", 32'(underflowA), 32'(ufExpA));
    if (!pixValidA) check("pixA_zero", 32'(pixDataA), 32'd0);
    // ---- reader B observation
    check("strobeB_grp", 32'({busB.nOE, busB.nLB, busB.nUB}), 32'({3{busB.nCE}}));
    if (!grantB) check("strobeB_nogrant", 32'(busB.nCE), 32'd1);
    if (!busB.nCE) obsAddrB.push_back(busB.sram_addr);
    check("ufB", 32'(underflowB), 32'(ufExpB));
    if (!pixValidB) check("pixB_zero", 32'(pixDataB), 32'd0);
    if (armKillB && !busB.nCE && prevLowB) begin
      reqStartB = 1'b1;
      armKillB  = 1'b0;
    end
    prevLowB = !busB.nCE;
    // ---- drive A
    lineStartA = 1'b0;
    pixRdA     = 1'b0;
    if (reqStartA) begin
      lineStartA = 1'b1;
      baseA      = startBaseA;
      reqStartA  = 1'b0;
      sbA.delete();
      for (int w = 0; w < 400; w++) begin
        a = startBaseA + 20'(w);
        sbA.push_back(memWord(a)[7:0]);
        sbA.push_back(memWord(a)[15:8]);
      end
    end else if (forceRdA) begin
      pixRdA = 1'b1;
    end else if (consumeA && pixValidA) begin
      exp = (sbA.size() != 0) ? 32'(sbA.pop_front()) : 32'hFFFF_FFFF;
      check("pixA", 32'(pixDataA), exp);
      pixRdA = 1'b1;
    end
    ufExpA = pixRdA && !pixValidA;
    if (toggleA) grantA = !grantA;
    // ---- drive B
    lineStartB = 1'b0;
    pixRdB     = 1'b0;
    if (reqStartB) begin
      lineStartB = 1'b1;
      baseB      = startBaseB;
      reqStartB  = 1'b0;
      sbB.delete();
      for (int w = 0; w < 4; w++) begin
        a = startBaseB + 20'(w);
        sbB.push_back(memWord(a)[7:0]);
        sbB.push_back(memWord(a)[15:8]);
      end
    end else if (consumeB && pixValidB) begin
      exp = (sbB.size() != 0) ? 32'(sbB.pop_front()) : 32'hFFFF_FFFF;
      check("pixB", 32'(pixDataB), exp);
      pixRdB = 1'b1;
    end
    ufExpB = pixRdB && !pixValidB;
  endtask

  task automatic drainA(input string tag, input int budget);
    int n = 0;
    tick();
    while (sbA.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check(tag, 32'(sbA.size()), 32'd0);
  endtask

  task automatic drainB(input string tag, input int budget);
    int n = 0;
    tick();
    while (sbB.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check(tag, 32'(sbB.size()), 32'd0);
  endtask

  logic [19:0] expAddrB [4];

  initial begin
    R = 1'b1;
    grantA = 1'b0; grantB = 1'b0;
    lineStartA = 1'b0; lineStartB = 1'b0;
    pixRdA = 1'b0; pixRdB = 1'b0;
    baseA = '0; baseB = '0;
    repeat (3) tick();

    // Reset values
    check("rst_nCE", 32'(busA.nCE), 32'd1);
    check("rst_nOE", 32'(busA.nOE), 32'd1);
    check("rst_nLB", 32'(busA.nLB), 32'd1);
    check("rst_nUB", 32'(busA.nUB), 32'd1);
    check("rst_nWE", 32'(busA.nWE), 32'd1);
    check("rst_addr", 32'(busA.sram_addr), 32'd0);
    check("rst_pixData", 32'(pixDataA), 32'd0);
    check("rst_pixValid", 32'(pixValidA), 32'd0);
    check("rst_underflow", 32'(underflowA), 32'd0);
    check("rst_state", 32'(u_dutA.state), 32'(IDLE));
    R = 1'b0;
    tick();

    // 1: full line, continuous consumer
    grantA = 1'b1; consumeA = 1'b1;
    startBaseA = 20'h00000; reqStartA = 1'b1;
    drainA("t1_timeout", 4000);
    repeat (5) tick();
    check("t1_state", 32'(u_dutA.state), 32'(DONE));
    check("t1_nCE", 32'(busA.nCE), 32'd1);
    check("t1_nWE", 32'(busA.nWE), 32'd1);
    check("t1_valid", 32'(pixValidA), 32'd0);

    // 2: stalled consumer caps outstanding reads at FIFO depth
    consumeA = 1'b0; issueCntA = 0;
    startBaseA = 20'h00000; reqStartA = 1'b1;
    repeat (40) tick();
    check("t2_issues", 32'(issueCntA), 32'd8);
    check("t2_valid", 32'(pixValidA), 32'd1);
    consumeA = 1'b1;
    drainA("t2_timeout", 4000);

    // 3: grant alternating every cycle
    toggleA = 1'b1;
    startBaseA = 20'h00000; reqStartA = 1'b1;
    drainA("t3_timeout", 6000);
    toggleA = 1'b0; grantA = 1'b1;
    repeat (4) tick();

    // 6: reads on an empty FIFO
    ufPulsesA = 0;
    forceRdA = 1'b1;
    repeat (3) tick();
    forceRdA = 1'b0;
    repeat (3) tick();
    check("t6_pulses", 32'(ufPulsesA), 32'd3);
    check("t6_valid", 32'(pixValidA), 32'd0);
    check("t6_pixData", 32'(pixDataA), 32'd0);
`ifdef SRAM_RD_UNDERFLOW_CNT_EN
    check("t6_ufcntA", 32'(ufRegA), 32'd3);
    check("t6_ufcntB", 32'(ufRegB), 32'd0);
`endif

    // 4: address wrap at top of SRAM, 4-word line
    expAddrB = '{20'hFFFFE, 20'hFFFFF, 20'h00000, 20'h00001};
    grantB = 1'b1; consumeB = 1'b1;
    obsAddrB.delete();
    startBaseB = 20'hFFFFE; reqStartB = 1'b1;
    drainB("t4_timeout", 200);
    repeat (5) tick();
    check("t4_addr_count", 32'(obsAddrB.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < obsAddrB.size()) check($sformatf("t4_addr%0d", i), 32'(obsAddrB[i]), 32'(expAddrB[i]));
    end
    check("t4_state", 32'(u_dutB.state), 32'(DONE));
    check("t4_nCE", 32'(busB.nCE), 32'd1);

    // 5: restart with two reads in flight; stale words must be dropped
    consumeB = 1'b0;
    startBaseB = 20'h00100; reqStartB = 1'b1;
    tick();
    startBaseB = 20'h002C0; armKillB = 1'b1;
    for (int n = 0; n < 50 && armKillB; n++) tick();
    check("t5_armed", 32'(armKillB), 32'd0);
    consumeB = 1'b1;
    drainB("t5_timeout", 200);
    repeat (5) tick();
    check("t5_state", 32'(u_dutB.state), 32'(DONE));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
